// File: rtl/mac_accum_requant.sv
// mac_accum_requant
//   Accumulates a job of signed partial sums from the upstream 8-lane MAC,
//   adds a per-job bias, requantizes (round-half-up arithmetic shift, optional
//   ReLU, saturation) and hands out one signed int8 result per job.
//
// Ports
//   clk, rst_n              clock, asynchronous active-low reset
//   start                   begin a job (sampled in IDLE only)
//   cfg_len/bias/shift/relu job configuration, captured on accepted start
//   in_valid/in_ready       partial-sum beat handshake, in_psum payload
//   out_valid/out_ready     result handshake, out_data payload (int8)
//   busy                    high whenever a job is in flight
module mac_accum_requant #(
    parameter int PSUM_W = 20,
    parameter int ACC_W  = 32,
    parameter int LEN_W  = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start,
    input  logic [LEN_W-1:0]         cfg_len,
    input  logic signed [ACC_W-1:0]  cfg_bias,
    input  logic [4:0]               cfg_shift,
    input  logic                     cfg_relu,
    input  logic                     in_valid,
    input  logic signed [PSUM_W-1:0] in_psum,
    output logic                     in_ready,
    output logic                     out_valid,
    output logic signed [7:0]        out_data,
    input  logic                     out_ready,
    output logic                     busy
);

    // The accumulator is sized so that the longest job cannot overflow it.
    if (PSUM_W + LEN_W > ACC_W) begin : g_width_check
        $error("mac_accum_requant: PSUM_W + LEN_W must not exceed ACC_W");
    end

    localparam int EXT_W = ACC_W + 2;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_QUANT = 2'd2,
        S_OUT   = 2'd3
    } state_e;

    state_e                    state_q, state_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [LEN_W-1:0]          count_q, count_d;
    logic [LEN_W-1:0]          len_q, len_d;
    logic signed [ACC_W-1:0]   bias_q, bias_d;
    logic [4:0]                shift_q, shift_d;
    logic                      relu_q, relu_d;
    logic signed [7:0]         out_data_q, out_data_d;

    logic signed [ACC_W-1:0]   psum_ext;
    logic [LEN_W-1:0]          count_inc;
    logic signed [EXT_W-1:0]   rnd;
    logic signed [EXT_W-1:0]   sum_ext;
    logic signed [EXT_W-1:0]   shifted;
    logic signed [EXT_W-1:0]   clipped;

    assign psum_ext  = {{(ACC_W-PSUM_W){in_psum[PSUM_W-1]}}, in_psum};
    assign count_inc = count_q + LEN_W'(1);

    // Requantization datapath. Two guard bits above ACC_W keep acc + bias +
    // rounding constant from wrapping before the shift.
    always_comb begin
        // NOTE: every combinational variable gets a default before any branch,
        // so no path leaves it unassigned and no latch is inferred.
        rnd = '0;
        if (shift_q != 5'd0) begin
            rnd[shift_q - 5'd1] = 1'b1;
        end
        sum_ext = {{2{acc_q[ACC_W-1]}}, acc_q} + {{2{bias_q[ACC_W-1]}}, bias_q} + rnd;
        shifted = sum_ext >>> shift_q;
        clipped = shifted;
        if (relu_q && clipped < 0) begin
            clipped = '0;
        end
        if (clipped > 127) begin
            clipped = EXT_W'(127);
        end else if (clipped < -128) begin
            clipped = -EXT_W'(128);
        end
    end

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        count_d    = count_q;
        len_d      = len_q;
        bias_d     = bias_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        out_data_d = out_data_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    len_d   = cfg_len;
                    bias_d  = cfg_bias;
                    shift_d = cfg_shift;
                    relu_d  = cfg_relu;
                    acc_d   = '0;
                    count_d = '0;
                    // An empty job still produces bias-only output.
                    state_d = (cfg_len != '0) ? S_ACCUM : S_QUANT;
                end
            end
            S_ACCUM: begin
                // in_ready is constant 1 here, so in_valid alone marks a beat.
                if (in_valid) begin
                    acc_d   = acc_q + psum_ext;
                    count_d = count_inc;
                    if (count_inc == len_q) begin
                        state_d = S_QUANT;
                    end
                end
            end
            S_QUANT: begin
                out_data_d = clipped[7:0];
                state_d    = S_OUT;
            end
            S_OUT: begin
                if (out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            acc_q      <= '0;
            count_q    <= '0;
            len_q      <= '0;
            bias_q     <= '0;
            shift_q    <= '0;
            relu_q     <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            count_q    <= count_d;
            len_q      <= len_d;
            bias_q     <= bias_d;
            shift_q    <= shift_d;
            relu_q     <= relu_d;
            out_data_q <= out_data_d;
        end
    end

    assign in_ready  = (state_q == S_ACCUM);
    assign out_valid = (state_q == S_OUT);
    assign out_data  = out_data_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_mac_accum_requant.sv
// tb_mac_accum_requant
//   Directed self-checking bench for mac_accum_requant. Inputs are driven and
//   outputs sampled 1 ns after the rising edge; expected results are
//   hand-computed constants.
module tb_mac_accum_requant;

    localparam int PSUM_W = 20;
    localparam int ACC_W  = 32;
    localparam int LEN_W  = 12;

    logic                     clk = 1'b0;
    logic                     rst_n = 1'b0;
    logic                     start = 1'b0;
    logic [LEN_W-1:0]         cfg_len = '0;
    logic signed [ACC_W-1:0]  cfg_bias = '0;
    logic [4:0]               cfg_shift = '0;
    logic                     cfg_relu = 1'b0;
    logic                     in_valid = 1'b0;
    logic signed [PSUM_W-1:0] in_psum = '0;
    logic                     in_ready;
    logic                     out_valid;
    logic signed [7:0]        out_data;
    logic                     out_ready = 1'b0;
    logic                     busy;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mac_accum_requant #(
        .PSUM_W (PSUM_W),
        .ACC_W  (ACC_W),
        .LEN_W  (LEN_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .cfg_len   (cfg_len),
        .cfg_bias  (cfg_bias),
        .cfg_shift (cfg_shift),
        .cfg_relu  (cfg_relu),
        .in_valid  (in_valid),
        .in_psum   (in_psum),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int len, input int bias, input int shift, input logic relu);
        start     = 1'b1;
        cfg_len   = LEN_W'(len);
        cfg_bias  = bias;
        cfg_shift = 5'(shift);
        cfg_relu  = relu;
        tick();
        start     = 1'b0;
    endtask

    task automatic send_beat(input string tag, input int v);
        in_valid = 1'b1;
        in_psum  = v[PSUM_W-1:0];
        check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
    endtask

    // Waits (bounded) for a result, checks it, completes the handshake.
    task automatic finish_out(input string tag, input int exp);
        int waited = 0;
        while (!out_valid && waited < 20) begin
            tick();
            waited++;
        end
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, $signed(out_data), exp);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check({tag, "_valid_drop"}, 32'(out_valid), 32'd0);
        check({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    initial begin
        // Reset state.
        #2;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", $signed(out_data), 0);
        check("rst_busy", 32'(busy), 32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // 100 - 20 + 7 + 13 = 100, plus latency check.
        start_job(4, 0, 0, 1'b0);
        check("j1_busy", 32'(busy), 32'd1);
        send_beat("j1_b1", 100);
        send_beat("j1_b2", -20);
        send_beat("j1_b3", 7);
        send_beat("j1_b4", 13);
        check("j1_quant_no_ready", 32'(in_ready), 32'd0);
        check("j1_quant_no_valid", 32'(out_valid), 32'd0);
        tick();
        check("j1_latency_valid", 32'(out_valid), 32'd1);
        finish_out("j1", 100);

        // (300 + 200 - 12 + 2) >>> 2 = 122; started back-to-back.
        start_job(2, -12, 2, 1'b0);
        send_beat("j2_b1", 300);
        send_beat("j2_b2", 200);
        finish_out("j2", 122);

        // (488 + 1) >>> 1 = 244 -> saturates to 127.
        start_job(2, -12, 1, 1'b0);
        send_beat("j3_b1", 300);
        send_beat("j3_b2", 200);
        finish_out("j3", 127);

        // Most negative partial sum: -128 clamp, then ReLU to 0.
        start_job(1, 0, 0, 1'b0);
        send_beat("j4_b1", -524288);
        finish_out("j4", -128);
        start_job(1, 0, 0, 1'b1);
        send_beat("j5_b1", -524288);
        finish_out("j5", 0);

        // Empty job: (-640 + 4) >>> 3 = -80, in_ready never rises.
        in_valid = 1'b1;
        in_psum  = 20'sd55;
        start_job(0, -640, 3, 1'b0);
        check("j6_quant_in_ready", 32'(in_ready), 32'd0);
        tick();
        check("j6_out_in_ready", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        finish_out("j6", -80);

        // Backpressure: 50 held for 5 cycles while in_valid and start poke it.
        start_job(1, 0, 0, 1'b0);
        send_beat("j7_b1", 50);
        tick();
        in_valid  = 1'b1;
        in_psum   = 20'sd1000;
        start     = 1'b1;
        cfg_len   = 12'd3;
        cfg_bias  = 32'sd999;
        cfg_shift = 5'd0;
        for (int i = 0; i < 5; i++) begin
            check("j7_hold_valid", 32'(out_valid), 32'd1);
            check("j7_hold_data", $signed(out_data), 50);
            check("j7_hold_in_ready", 32'(in_ready), 32'd0);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        finish_out("j7", 50);

        // Reset mid-job after 2 of 4 beats, then a clean job.
        start_job(4, 0, 0, 1'b0);
        send_beat("j8_b1", 40);
        send_beat("j8_b2", 40);
        #2;
        rst_n = 1'b0;
        #1;
        check("j8_rst_in_ready", 32'(in_ready), 32'd0);
        check("j8_rst_busy", 32'(busy), 32'd0);
        check("j8_rst_out_valid", 32'(out_valid), 32'd0);
        check("j8_rst_out_data", $signed(out_data), 0);
        tick();
        rst_n = 1'b1;
        tick();
        tick();
        check("j8_waits_idle", 32'(busy), 32'd0);
        start_job(2, 5, 0, 1'b0);
        send_beat("j9_b1", 10);
        send_beat("j9_b2", 20);
        finish_out("j9", 35);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
